// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter and its load-response FIFO.
package wb_arbiter_pkg;

  localparam int ADDR_WIDTH     = 5;
  localparam int REG_FILE_WIDTH = 32;
  localparam int WB_FIFO_DEPTH  = 4;
  localparam int ZERO_REG       = 0;

  // Source that drives the write-back output stage in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Circular load-response FIFO with a per-entry live bit. Entries can be
// killed by address (a younger ALU write to the same register) and keep
// their slot until popped; killed entries never report a pending hit.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = WB_FIFO_DEPTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = REG_FILE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     push_kill,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [ADDR_W-1:0]        kill_addr,
  input  logic [ADDR_W-1:0]        chk_addr,
  output logic                     head_live,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic                     chk_hit,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W-2:0]  rd_idx, wr_idx;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  live;

  assign rd_idx    = rd_ptr[PTR_W-2:0];
  assign wr_idx    = wr_ptr[PTR_W-2:0];
  // The extra pointer bit makes the difference the true fill level.
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == PTR_W'(DEPTH));

  assign head_live = live[rd_idx];
  assign head_addr = addr_mem[rd_idx];
  assign head_data = data_mem[rd_idx];

  // Payload storage: written on push only.
  // NOTE: the payload arrays carry no reset; an entry is only ever read after
  // a push has written it, and the live bits alone decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx] <= push_addr;
      data_mem[wr_idx] <= push_data;
    end
  end

  // Pointers and live bits; a push overrides a same-cycle kill on its slot.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values and the later assignments in this block win cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      live   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && addr_mem[i] == kill_addr) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_idx] <= 1'b0;
        rd_ptr       <= rd_ptr + 1'b1;
      end
      if (push) begin
        live[wr_idx] <= !push_kill;
        wr_ptr       <= wr_ptr + 1'b1;
      end
    end
  end

  // Any live entry destined for the probed register.
  // NOTE: chk_hit gets a default before the loop so no latch is inferred.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && addr_mem[i] == chk_addr) chk_hit = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load responses into
// one registered register-file write per cycle. ALU results always win and
// kill older buffered loads to the same register.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_FIFO_DEPTH,
  parameter int ADDR_W       = ADDR_WIDTH,
  parameter int DATA_W       = REG_FILE_WIDTH,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic [ADDR_W-1:0]      chk_addr,
  output logic                   pend_hit,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   wrt_en,
  output logic [ADDR_W-1:0]      addrD,
  output logic [DATA_W-1:0]      d
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              fifo_empty, fifo_full, fifo_hit, head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              mem_accept, push_kill, pop;
  wb_src_e           src;
  logic              wrt_en_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  // Ready depends only on the current fill level, never on a same-cycle pop.
  assign mem_ready  = !fifo_full;
  assign mem_accept = mem_valid && mem_ready;
  // A load to r0, or to the register the ALU writes this cycle, is dead on entry.
  assign push_kill  = (ZERO_DISCARD && mem_addr == ZERO_ADDR) ||
                      (alu_valid && mem_addr == alu_addr);
  assign src        = alu_valid   ? SRC_ALU  :
                      !fifo_empty ? SRC_FIFO : SRC_NONE;
  assign pop        = (src == SRC_FIFO);
  assign pend_hit   = fifo_hit || (wrt_en && addrD == chk_addr);

  wb_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (mem_accept),
    .push_addr(mem_addr),
    .push_data(mem_data),
    .push_kill(push_kill),
    .pop      (pop),
    .kill_en  (alu_valid),
    .kill_addr(alu_addr),
    .chk_addr (chk_addr),
    .head_live(head_live),
    .head_addr(head_addr),
    .head_data(head_data),
    .chk_hit  (fifo_hit),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .occupancy(occupancy)
  );

  // Select the next write: ALU first, then the FIFO head, else idle.
  always_comb begin
    wrt_en_nxt = 1'b0;
    addr_nxt   = addrD;
    data_nxt   = d;
    case (src)
      SRC_ALU: begin
        wrt_en_nxt = !(ZERO_DISCARD && alu_addr == ZERO_ADDR);
        addr_nxt   = alu_addr;
        data_nxt   = alu_data;
      end
      SRC_FIFO: begin
        wrt_en_nxt = head_live;
        addr_nxt   = head_addr;
        data_nxt   = head_data;
      end
      default: ;
    endcase
  end

  // Registered write port so the register file sees stable address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrt_en <= 1'b0;
      addrD  <= '0;
      d      <= '0;
    end else begin
      wrt_en <= wrt_en_nxt;
      addrD  <= addr_nxt;
      d      <= data_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued as stimulus is
// issued and a negedge monitor compares every write the DUT presents.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = REG_FILE_WIDTH;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alu_valid, mem_valid, mem_ready;
  logic [AW-1:0]          alu_addr, mem_addr, chk_addr;
  logic [DW-1:0]          alu_data, mem_data;
  logic                   pend_hit, wrt_en;
  logic [$clog2(DEPTH):0] occupancy;
  logic [AW-1:0]          addrD;
  logic [DW-1:0]          d;

  wb_arbiter #(
    .DEPTH       (DEPTH),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .ZERO_DISCARD(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .chk_addr (chk_addr),
    .pend_hit (pend_hit),
    .occupancy(occupancy),
    .wrt_en   (wrt_en),
    .addrD    (addrD),
    .d        (d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    exp_q.push_back('{addr: a, data: v});
  endtask

  // Apply one cycle of stimulus; returns 1 time unit after the capturing edge.
  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    @(posedge clk); #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: every asserted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wrt_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", addrD, d);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(addrD), 64'(e.addr));
        check("write_data", 64'(d), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    chk_addr  = '0;

    // Reset then idle.
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_wrt_en", 64'(wrt_en), 64'd0);
      check("rst_mem_ready", 64'(mem_ready), 64'd1);
      check("rst_occupancy", 64'(occupancy), 64'd0);
    end
    check("rst_addrD", 64'(addrD), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    rst = 1'b0;
    repeat (2) begin
      idle();
      check("idle_wrt_en", 64'(wrt_en), 64'd0);
      check("idle_mem_ready", 64'(mem_ready), 64'd1);
      check("idle_occupancy", 64'(occupancy), 64'd0);
    end

    // ALU only: one write, held one cycle.
    expect_wr(5'd5, 32'hDEADBEEF);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    check("alu_wrt_en", 64'(wrt_en), 64'd1);
    idle();
    check("alu_wrt_en_drop", 64'(wrt_en), 64'd0);

    // Contention: r3, r4 from the ALU, then buffered r7.
    expect_wr(5'd3, 32'h22);
    expect_wr(5'd4, 32'h33);
    expect_wr(5'd7, 32'h11);
    drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd7, 32'h11);
    check("cont_occ1", 64'(occupancy), 64'd1);
    drive(1'b1, 5'd4, 32'h33, 1'b0, '0, '0);
    check("cont_occ2", 64'(occupancy), 64'd1);
    idle();
    check("cont_occ3", 64'(occupancy), 64'd0);
    idle();

    // Full: four loads buffered behind an ALU stream, then drained in order.
    for (int i = 1; i <= 4; i++) begin
      expect_wr(AW'(16 + i), DW'(32'h200 + i));
      drive(1'b1, AW'(16 + i), DW'(32'h200 + i), 1'b1, AW'(i), DW'(32'h100 + i));
    end
    check("full_mem_ready", 64'(mem_ready), 64'd0);
    check("full_occ", 64'(occupancy), 64'd4);
    expect_wr(5'd21, 32'h205);
    drive(1'b1, 5'd21, 32'h205, 1'b1, 5'd8, 32'h999);
    check("full_hold_occ", 64'(occupancy), 64'd4);
    check("full_hold_ready", 64'(mem_ready), 64'd0);
    for (int i = 1; i <= 4; i++) expect_wr(AW'(i), DW'(32'h100 + i));
    for (int i = 1; i <= 4; i++) begin
      idle();
      check("drain_occ", 64'(occupancy), 64'(4 - i));
    end
    check("drain_mem_ready", 64'(mem_ready), 64'd1);
    idle();

    // WAW kill: buffered r9 killed by a younger ALU write to r9.
    chk_addr = 5'd9;
    expect_wr(5'd12, 32'h12);
    drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd9, 32'h99);
    check("waw_pend_fifo", 64'(pend_hit), 64'd1);
    expect_wr(5'd9, 32'h55);
    drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0);
    check("waw_pend_out", 64'(pend_hit), 64'd1);
    check("waw_occ", 64'(occupancy), 64'd1);
    idle();
    check("waw_killed_pop", 64'(wrt_en), 64'd0);
    check("waw_pend_clear", 64'(pend_hit), 64'd0);
    check("waw_occ_empty", 64'(occupancy), 64'd0);

    // Same-cycle ALU and load to one register: the load is older and dies.
    chk_addr = 5'd6;
    expect_wr(5'd6, 32'h66);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h77);
    check("same_pend", 64'(pend_hit), 64'd1);
    check("same_occ", 64'(occupancy), 64'd1);
    idle();
    check("same_killed_pop", 64'(wrt_en), 64'd0);
    check("same_pend_clear", 64'(pend_hit), 64'd0);

    // Register 0 from either source is never written.
    chk_addr = 5'd0;
    drive(1'b1, 5'd0, 32'hAA, 1'b0, '0, '0);
    check("zero_alu", 64'(wrt_en), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hBB);
    check("zero_mem_occ", 64'(occupancy), 64'd1);
    check("zero_mem_pend", 64'(pend_hit), 64'd0);
    idle();
    check("zero_mem_pop", 64'(wrt_en), 64'd0);
    check("zero_mem_empty", 64'(occupancy), 64'd0);

    // Reset with three loads buffered drops them all.
    for (int i = 1; i <= 3; i++) begin
      expect_wr(AW'(24 + i), DW'(32'h300 + i));
      drive(1'b1, AW'(24 + i), DW'(32'h300 + i), 1'b1, AW'(10 + i), DW'(32'h400 + i));
    end
    check("pre_rst_occ", 64'(occupancy), 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_wrt_en", 64'(wrt_en), 64'd0);
    check("mid_rst_ready", 64'(mem_ready), 64'd1);
    rst = 1'b0;
    repeat (4) begin
      idle();
      check("post_rst_wrt_en", 64'(wrt_en), 64'd0);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
